// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame geometry, default baud divisor.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package uart_pkg;

    localparam int FRAME_BITS           = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Counter width for a divisor, kept at least one bit wide for degenerate divisors.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; read data is the combinational head entry.
// Latency: one cycle from push to empty=0; push is dropped while the registered full flag is set.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count, so a same-cycle pop never frees a slot early.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; tx is registered and idles high.
// Latency: byte written into an empty FIFO while idle drives the start bit two edges later; writes dropped while full.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int                CNT_W     = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(FRAME_BITS - 1);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] fifo_dat;
    logic       pop;
    logic       bit_done;
    logic       tx_nxt;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_dat),
        .full      (full),
        .empty     (empty)
    );

    assign bit_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (bit_done) begin
                    state_nxt = empty ? IDLE : START;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        tx_nxt = 1'b1;
        busy   = (state != IDLE);
        case (state)
            IDLE: begin
                pop    = !empty;
                tx_nxt = 1'b1;
            end
            START: begin
                tx_nxt = 1'b0;
            end
            DATA: begin
                tx_nxt = shreg[0];
            end
            STOP: begin
                pop    = bit_done && !empty;
                tx_nxt = 1'b1;
            end
            default: begin
                pop    = 1'b0;
                tx_nxt = 1'b1;
            end
        endcase
    end

    // tx trails the state register by one edge, which keeps every bit exactly CLKS_PER_BIT wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            tx <= tx_nxt;
            if ((state == IDLE) || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (pop) begin
                shreg <= fifo_dat;
            end else if ((state == DATA) && bit_done) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if ((state == DATA) && bit_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, sets clk cycles per serial bit (9600 baud at 100 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, sets transmit FIFO entries; SHALL be a power of two, 2 or more.
REQ-003 clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe for wr_data.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 full  output  1  FIFO full; writes are ignored while full=1.
REQ-008 empty  output  1  FIFO holds no pending bytes.
REQ-009 busy  output  1  a frame is in progress (state other than IDLE).
REQ-010 tx  output  1  serial line; registered output; idle level is 1.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, eight data bits LSB first, one stop bit 1.
REQ-012 Each bit SHALL hold on tx for exactly CLKS_PER_BIT clk cycles.
REQ-013 Write acceptance: a write is accepted on an edge where wr_en=1 and full=0; the byte is appended to the FIFO.
REQ-014 Write rejection: wr_en=1 while full=1 SHALL drop the byte and leave FIFO contents unchanged.
REQ-015 full SHALL reflect the registered count, so a pop and a write in the same cycle while full still reject the write.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE with empty=0 -> pop the FIFO head into the shift register and enter START; tx falls to 0 one cycle after the edge where IDLE observes empty=0.
REQ-018 Latency: a byte written at edge E into an empty FIFO while IDLE SHALL produce tx=0 after edge E+2.
REQ-019 START -> DATA after CLKS_PER_BIT cycles.
REQ-020 DATA shifts out bit_idx 0..7 and moves to STOP after 8 bit periods; bit_idx is 3 bits and wraps only on exit.
REQ-021 STOP -> START directly if empty=0 at the final stop-bit cycle (next byte popped, no idle gap); otherwise -> IDLE.
REQ-022 A simultaneous FIFO write and pop SHALL leave the count unchanged and lose no data.
REQ-023 Baud counter: width $clog2(CLKS_PER_BIT); reloads to 0 at every bit boundary; never free-runs outside a frame.
REQ-024 A write in the same cycle as the FSM pops the last entry SHALL be transmitted as the next frame.

Reset
REQ-025 On rst=1 at an edge: tx=1, state=IDLE, FIFO empty (empty=1, full=0), busy=0, baud counter and bit_idx cleared.
REQ-026 Reset mid-frame SHALL abort the frame immediately (tx=1 after that edge) and discard all queued bytes.
REQ-027 Writes presented while rst=1 SHALL be ignored.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state encoding, the frame bit count (8), and the default CLKS_PER_BIT.
REQ-029 The FIFO SHALL be a sub-module sync_fifo (parameters width 8 and FIFO_DEPTH; ports push, pop, full, empty).
REQ-030 The FSM, baud counter and shift register SHALL reside in uart_tx.

Verification
REQ-031 Single byte: CLKS_PER_BIT=4, write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; then busy=0 and tx=1.
REQ-032 Back-to-back: write 0x00 then 0xFF on consecutive cycles -> 20 contiguous bit periods with no idle gap between the stop bit and the next start bit.
REQ-033 Overflow: FIFO_DEPTH=4, write 6 bytes on consecutive cycles from idle -> bytes 1-5 transmitted in order, byte 6 dropped, full=1 during the cycle of write 6.
REQ-034 Reset mid-frame: assert rst during DATA bit 3 -> tx=1 next cycle, empty=1, no further frames.
REQ-035 Default timing: CLKS_PER_BIT=10417 with a 100 MHz clk and a bench sampler at 9600 baud mid-bit, send the 52-byte program image -> every byte decoded correctly.
